tt_vec_checker: RTL

TT_VEC_CHECKER -- requirements
Module: tt_vec_checker

---
 rtl/tt_vec_checker.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tt_vec_checker.sv
// tt_vec_checker: stored-vector test sequencer.
// A small table holds {stimulus, expected response, compare mask} entries.
// A run drives each stimulus onto dut_stim, waits LAT cycles, and compares
// dut_resp with the expected value under the mask. It reports a mismatch
// count, the index of the first failing vector, and a pass flag.
module tt_vec_checker #(
  parameter  int W     = 8,
  parameter  int DEPTH = 16,
  parameter  int LAT   = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_stim,
  input  logic [W-1:0]  wr_exp,
  input  logic [W-1:0]  wr_mask,
  input  logic [AW:0]   num_vec,
  input  logic          start,
  input  logic          abort,
  output logic [W-1:0]  dut_stim,
  input  logic [W-1:0]  dut_resp,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] first_err_idx,
  output logic          first_err_valid
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // DEPTH expressed at the width of num_vec, so the run length can be clamped
  localparam logic [AW:0] DEPTH_N   = (AW+1)'(DEPTH);
  // WAIT occupies LAT-1 cycles, so its counter runs from 0 to LAT-2
  localparam logic [3:0]  WAIT_LAST = 4'(LAT - 2);

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] last_idx;
  logic [3:0]    wait_cnt;

  logic [W-1:0]  stim_mem [DEPTH];
  logic [W-1:0]  exp_mem  [DEPTH];
  logic [W-1:0]  mask_mem [DEPTH];

  logic          table_open;
  logic          table_wr;
  logic [AW:0]   run_len;
  logic          mismatch;
  logic          last_vec;

  // The table may be rewritten only while no run is in progress; the run
  // length is clamped to the table size; the check is made for the current vector.
  always_comb begin
    table_open = (state == IDLE) || (state == DONE);
    table_wr   = wr_en && table_open;
    run_len    = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
    mismatch   = |((dut_resp ^ exp_mem[idx]) & mask_mem[idx]);
    last_vec   = (idx == last_idx);
  end

  // Vector table storage. It is not reset, so the contents survive a reset.
  always_ff @(posedge clk) begin
    if (table_wr) begin
      stim_mem[wr_addr] <= wr_stim;
      exp_mem[wr_addr]  <= wr_exp;
      mask_mem[wr_addr] <= wr_mask;
    end
  end

  // Run sequencer. abort takes priority over everything else, including a
  // start in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      last_idx        <= '0;
      wait_cnt        <= '0;
      dut_stim        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= 8'd0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_cnt         <= 8'd0;
            first_err_valid <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            idx             <= '0;
            if (run_len == '0) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              last_idx <= AW'(run_len - (AW+1)'(1));
              state    <= DRIVE;
              busy     <= 1'b1;
            end
          end
        end

        DRIVE: begin
          dut_stim <= stim_mem[idx];
          wait_cnt <= 4'd0;
          if (LAT == 1) begin
            state <= CHECK;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        CHECK: begin
          if (mismatch) begin
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            if (!first_err_valid) begin
              first_err_idx   <= idx;
              first_err_valid <= 1'b1;
            end
          end
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            idx   <= idx + AW'(1);
            state <= DRIVE;
          end
        end

        DONE: begin
          if (start) begin
            err_cnt         <= 8'd0;
            first_err_valid <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            idx             <= '0;
            if (run_len == '0) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              last_idx <= AW'(run_len - (AW+1)'(1));
              state    <= DRIVE;
              busy     <= 1'b1;
            end
          end else begin
            done <= 1'b1;
            pass <= (err_cnt == 8'd0);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
